// File: rtl/elbeth_mem_responder.sv
// elbeth_mem_responder: single-port word memory behind a request/ready
// handshake with a configurable number of wait states. Each request is
// answered by a one-cycle mem_ready pulse, with mem_error set for illegal
// lane patterns or out-of-range word indices.
module elbeth_mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_size,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;

  logic        lat_rw;
  logic [29:0] lat_idx;
  logic [3:0]  lat_size;
  logic [31:0] lat_wdata;

  logic        req_rw;
  logic [29:0] req_idx;
  logic [3:0]  req_size;
  logic [31:0] req_wdata;
  logic        size_ok;
  logic        req_err;
  logic        enter_resp;
  logic        do_write;
  logic [AW-1:0] widx;

  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] storage [DEPTH];

  logic        unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  // State register with counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (mem_en) begin
          if (WAIT_STATES > 0) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!mem_en) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the response edge is the acceptance edge, so the
  // live inputs stand in for the latched request while in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      req_rw    = mem_rw;
      req_idx   = mem_addr[31:2];
      req_size  = mem_size;
      req_wdata = mem_wdata;
    end else begin
      req_rw    = lat_rw;
      req_idx   = lat_idx;
      req_size  = lat_size;
      req_wdata = lat_wdata;
    end
  end

  // Legal lane patterns: single bytes, aligned halves, full word
  always_comb begin
    case (req_size)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: size_ok = 1'b1;
      default:                   size_ok = 1'b0;
    endcase
  end

  assign req_err    = !size_ok || ({2'b00, req_idx} >= DEPTH);
  assign enter_resp = (state_next == S_RESP) && !rst;
  assign do_write   = enter_resp && req_rw && !req_err;
  assign widx       = req_idx[AW-1:0];

  // Output decode from state and response registers
  always_comb begin
    mem_ready = (state == S_RESP);
    mem_error = (state == S_RESP) && err_q;
    mem_rdata = rdata_q;
  end

  // Request latch at acceptance and response capture on entry to RESP
  always_ff @(posedge clk) begin
    if (state == S_IDLE && mem_en) begin
      lat_rw    <= mem_rw;
      lat_idx   <= mem_addr[31:2];
      lat_size  <= mem_size;
      lat_wdata <= mem_wdata;
    end
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= req_err;
      rdata_q <= (!req_rw && !req_err) ? storage[widx] : '0;
    end
  end

  // Byte-lane write into storage; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_size[i]) storage[widx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule
